hdlc_tx_framer: RTL and testbench

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_pkg.sv | 27 ++
 rtl/hdlc_crc16.sv | 32 +++
 rtl/hdlc_tx_framer.sv | 213 +++++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared types and constants for the HDLC transmit framer.
//   hdlc_state_e : framer FSM states
//   HDLC_FLAG    : opening/closing flag octet
//   CRC16_POLY   : FCS generator polynomial (x^16+x^15+x^2+1)
//   CRC16_INIT   : FCS register value at frame start
package hdlc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned CNT_W  = 5;   // counts up to 16: FCS bits plus a trailing-stuff marker
  localparam int unsigned ONES_W = 3;

  localparam logic [BYTE_W-1:0] HDLC_FLAG  = 8'h7E;
  localparam logic [CRC_W-1:0]  CRC16_POLY = 16'h8005;
  localparam logic [CRC_W-1:0]  CRC16_INIT = 16'h0000;
  localparam logic [ONES_W-1:0] STUFF_RUN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    FCS,
    END_FLAG,
    ABORT
  } hdlc_state_e;

endpackage

// File: rtl/hdlc_crc16.sv
// hdlc_crc16: bit-serial CRC-16, MSB-feedback form, one data bit per enabled cycle.
//   Clk, Rst  : clock, async active-high reset
//   i_clear   : reload CRC16_INIT (has priority over i_enable)
//   i_enable  : absorb i_bit this cycle
//   i_bit     : serial data bit in transmit order
//   o_crc     : current CRC register
module hdlc_crc16 import hdlc_pkg::*; (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = i_bit ^ r_crc[CRC_W-1];
  assign o_crc = r_crc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_crc <= CRC16_INIT;
    end else if (i_clear) begin
      r_crc <= CRC16_INIT;
    end else if (i_enable) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC16_POLY : '0);
    end
  end

endmodule

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: HDLC transmit framer - flag, zero-stuffed data + CRC-16 FCS, flag; abort support.
//   Clk, Rst         : clock, async active-high reset
//   Tx_Enable        : start request (IDLE only, needs Tx_DataAvail)
//   Tx_Data          : show-ahead byte from TX buffer
//   Tx_DataAvail     : TX buffer not empty
//   Tx_AbortFrame    : abort request
//   Tx_RdBuff        : byte consumed this cycle (combinational)
//   Tx               : registered serial line, idle-high
//   Tx_ValidFrame    : frame in progress on Tx
//   Tx_AbortedTrans  : sticky abort flag, cleared on next frame start
//   Tx_Done          : last end-flag bit on Tx
//
// The state/counter registers describe the bit currently on Tx; r_tx is loaded
// with the bit the next-state values will describe, so Tx stays a flop output.
module hdlc_tx_framer import hdlc_pkg::*; (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Enable,
  input  logic [BYTE_W-1:0] Tx_Data,
  input  logic              Tx_DataAvail,
  input  logic              Tx_AbortFrame,
  output logic              Tx_RdBuff,
  output logic              Tx,
  output logic              Tx_ValidFrame,
  output logic              Tx_AbortedTrans,
  output logic              Tx_Done
);

  hdlc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic              r_stuff, w_stuff_nxt;   // current bit is an inserted zero
  logic [ONES_W-1:0] r_ones, w_ones_nxt;
  logic              r_tx, r_valid, r_done, r_aborted;

  logic              w_fetch, w_start;
  logic              w_tx_nxt, w_valid_nxt, w_done_nxt, w_aborted_nxt;
  logic              w_crc_clr, w_crc_en, w_crc_nxt0;
  logic [CRC_W-1:0]  w_crc;
  logic [ONES_W-1:0] w_ones_upd;
  logic              w_stuff_due;

  // Run length including the bit now on Tx; a stuff zero resets it naturally.
  assign w_ones_upd  = r_tx ? (r_ones + ONES_W'(1)) : '0;
  assign w_stuff_due = (w_ones_upd == STUFF_RUN);

  hdlc_crc16 u_crc (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_clear  (w_crc_clr),
    .i_enable (w_crc_en),
    .i_bit    (r_tx),
    .o_crc    (w_crc)
  );

  // State and output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_stuff   <= 1'b0;
      r_ones    <= '0;
      r_tx      <= 1'b1;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_stuff   <= w_stuff_nxt;
      r_ones    <= w_ones_nxt;
      r_tx      <= w_tx_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_stuff_nxt = 1'b0;
    w_ones_nxt  = r_ones;
    w_fetch     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Tx_Enable && Tx_DataAvail) begin
          w_start     = 1'b1;
          w_state_nxt = START_FLAG;
          w_cnt_nxt   = '0;
          w_ones_nxt  = '0;
        end
      end
      START_FLAG: begin
        if (Tx_AbortFrame) begin
          w_state_nxt = ABORT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(7)) begin
          w_cnt_nxt = '0;
          if (Tx_DataAvail) begin
            w_fetch     = 1'b1;
            w_state_nxt = DATA;
            w_shift_nxt = Tx_Data;
          end else begin
            w_state_nxt = FCS;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (Tx_AbortFrame) begin
          w_state_nxt = ABORT;
          w_cnt_nxt   = '0;
        end else if (r_stuff) begin
          w_ones_nxt = '0;           // shift stalls for the inserted zero
        end else begin
          w_ones_nxt  = w_ones_upd;
          w_stuff_nxt = w_stuff_due;
          w_shift_nxt = r_shift >> 1;
          if (r_cnt == CNT_W'(7)) begin
            w_cnt_nxt = '0;
            if (Tx_DataAvail) begin
              w_fetch     = 1'b1;
              w_shift_nxt = Tx_Data;
            end else begin
              w_state_nxt = FCS;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      FCS: begin
        if (Tx_AbortFrame) begin
          w_state_nxt = ABORT;
          w_cnt_nxt   = '0;
        end else if (r_stuff) begin
          w_ones_nxt = '0;
          // cnt==16 marks a stuff bit that follows the last FCS bit
          if (r_cnt == CNT_W'(16)) begin
            w_state_nxt = END_FLAG;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_ones_nxt  = w_ones_upd;
          w_stuff_nxt = w_stuff_due;
          if (r_cnt == CNT_W'(15)) begin
            if (w_stuff_due) begin
              w_cnt_nxt = CNT_W'(16);
            end else begin
              w_state_nxt = END_FLAG;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      END_FLAG, ABORT: begin
        if (r_cnt == CNT_W'(7)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: buffer read, CRC control and the next bit for the Tx flop
  always_comb begin
    Tx_RdBuff = w_fetch;
    w_crc_clr = w_start;
    w_crc_en  = (r_state == DATA) && !r_stuff;
    // FCS bit 0 may be needed in the same cycle the last data bit is absorbed
    w_crc_nxt0 = w_crc_en ? (r_tx ^ w_crc[CRC_W-1]) : w_crc[0];
    w_tx_nxt   = 1'b1;
    case (w_state_nxt)
      START_FLAG, END_FLAG: w_tx_nxt = HDLC_FLAG[w_cnt_nxt[2:0]];
      DATA:                 w_tx_nxt = w_stuff_nxt ? 1'b0 : w_shift_nxt[0];
      FCS: begin
        if (w_stuff_nxt)
          w_tx_nxt = 1'b0;
        else if (w_cnt_nxt == '0)
          w_tx_nxt = w_crc_nxt0;
        else
          w_tx_nxt = w_crc[w_cnt_nxt[3:0]];
      end
      ABORT:                w_tx_nxt = (w_cnt_nxt != '0);
      default:              w_tx_nxt = 1'b1;
    endcase
    w_valid_nxt   = (w_state_nxt != IDLE);
    w_done_nxt    = (w_state_nxt == END_FLAG) && (w_cnt_nxt == CNT_W'(7));
    w_aborted_nxt = w_start ? 1'b0
                  : (r_aborted || ((w_state_nxt == ABORT) && (r_state != ABORT)));
  end

  assign Tx              = r_tx;
  assign Tx_ValidFrame   = r_valid;
  assign Tx_AbortedTrans = r_aborted;
  assign Tx_Done         = r_done;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: directed bench for hdlc_tx_framer.
// Each frame is run for a fixed 64-cycle window; cycle 0 is the Tx_Enable cycle and
// bit c of each record vector holds the output sampled in cycle c.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Enable;
  logic [7:0] Tx_Data;
  logic       Tx_DataAvail;
  logic       Tx_AbortFrame;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  hdlc_tx_framer dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_Enable       (Tx_Enable),
    .Tx_Data         (Tx_Data),
    .Tx_DataAvail    (Tx_DataAvail),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx_RdBuff       (Tx_RdBuff),
    .Tx              (Tx),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_AbortedTrans (Tx_AbortedTrans),
    .Tx_Done         (Tx_Done)
  );

  always #5 Clk = ~Clk;

  // TX buffer model: show-ahead, popped when Tx_RdBuff is seen
  logic [7:0] mem [0:7];
  int n_bytes;
  int rd_ptr;
  assign Tx_DataAvail = (rd_ptr < n_bytes);
  assign Tx_Data      = mem[rd_ptr[2:0]];

  int total;
  int bad;

  logic [63:0] rec_tx, rec_vld, rec_rd, rec_done, rec_ab;
  logic [63:0] exp_tx, exp_vld, exp_rd, exp_done, exp_ab;
  int          pos;
  logic [15:0] m_crc;
  int          m_ones;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    mem[0]  = b0;
    mem[1]  = b1;
    mem[2]  = b2;
    n_bytes = n;
    rd_ptr  = 0;
  endtask

  task automatic tick(input int c);
    @(negedge Clk);
    rec_tx[c]   = Tx;
    rec_vld[c]  = Tx_ValidFrame;
    rec_rd[c]   = Tx_RdBuff;
    rec_done[c] = Tx_Done;
    rec_ab[c]   = Tx_AbortedTrans;
    @(posedge Clk);
    #1;
    if (rec_rd[c]) rd_ptr++;
    Tx_Enable     = 1'b0;
    Tx_AbortFrame = 1'b0;
  endtask

  task automatic run_frame(input int abort_cyc);
    Tx_Enable = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (c == abort_cyc) Tx_AbortFrame = 1'b1;
      tick(c);
    end
  endtask

  task automatic new_exp();
    exp_tx   = '1;
    exp_vld  = '0;
    exp_rd   = '0;
    exp_done = '0;
    exp_ab   = '0;
    pos      = 1;
  endtask

  // Append n raw bits, LSB first
  task automatic put(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx[pos] = bits[i];
      pos++;
    end
  endtask

  task automatic finish_exp(input bit has_done);
    for (int c = 1; c < pos; c++) exp_vld[c] = 1'b1;
    if (has_done) exp_done[pos-1] = 1'b1;
  endtask

  // Reference framing: emit a data/FCS bit with zero insertion after five ones
  task automatic emit(input logic b);
    exp_tx[pos] = b;
    pos++;
    m_ones = b ? m_ones + 1 : 0;
    if (m_ones == 5) begin
      exp_tx[pos] = 1'b0;
      pos++;
      m_ones = 0;
    end
  endtask

  task automatic model_frame(input int n);
    logic b, fb;
    put(64'h7E, 8);
    m_crc  = 16'h0000;
    m_ones = 0;
    if (n > 0) exp_rd[8] = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        b     = mem[k][i];
        fb    = b ^ m_crc[15];
        m_crc = {m_crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        if (i == 7 && k < n - 1) exp_rd[pos] = 1'b1;
        emit(b);
      end
    end
    for (int i = 0; i < 16; i++) emit(m_crc[i]);
    put(64'h7E, 8);
    finish_exp(1'b1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_tx"},   rec_tx,   exp_tx);
    chk({tag, "_vld"},  rec_vld,  exp_vld);
    chk({tag, "_rd"},   rec_rd,   exp_rd);
    chk({tag, "_done"}, rec_done, exp_done);
    chk({tag, "_ab"},   rec_ab,   exp_ab);
  endtask

  task automatic exp_zero_frame();
    new_exp();
    put(64'h7E, 8);
    put(64'h0, 32);
    put(64'h7E, 8);
    exp_rd[8]  = 1'b1;
    exp_rd[16] = 1'b1;
    finish_exp(1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst           = 1'b1;
    Tx_Enable     = 1'b0;
    Tx_AbortFrame = 1'b0;
    load(0, 8'h00, 8'h00, 8'h00);

    #12;
    chk("reset_outs", 64'({Tx, Tx_ValidFrame, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}), 64'b10000);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Idle line, including a Tx_Enable with an empty buffer
    for (int c = 0; c < 20; c++) begin
      if (c == 10) Tx_Enable = 1'b1;
      tick(c);
      chk("idle", 64'({rec_tx[c], rec_vld[c]}), 64'b10);
    end

    // Two zero bytes: flag, 32 zeros, flag
    load(2, 8'h00, 8'h00, 8'h00);
    exp_zero_frame();
    run_frame(-1);
    check_frame("zero2");

    // Same frame, abort during END_FLAG must be ignored
    load(2, 8'h00, 8'h00, 8'h00);
    exp_zero_frame();
    run_frame(44);
    check_frame("endflag_abort");

    // 0xFF: one stuffed zero, FCS = 16'h0202
    load(1, 8'hFF, 8'h00, 8'h00);
    new_exp();
    put(64'h7E, 8);
    put(64'h1DF, 9);
    put(64'h0202, 16);
    put(64'h7E, 8);
    exp_rd[8] = 1'b1;
    finish_exp(1'b1);
    run_frame(-1);
    check_frame("ff");

    // Abort during the second data byte
    load(3, 8'h00, 8'h00, 8'h00);
    new_exp();
    put(64'h7E, 8);
    put(64'h0, 12);
    put(64'hFE, 8);
    exp_rd[8]  = 1'b1;
    exp_rd[16] = 1'b1;
    finish_exp(1'b0);
    for (int c = 21; c < 64; c++) exp_ab[c] = 1'b1;
    run_frame(20);
    check_frame("abort");

    // Run of ones spanning a byte boundary; Enable with Abort in IDLE starts the frame
    load(2, 8'hF0, 8'h1F, 8'h00);
    new_exp();
    model_frame(2);
    exp_ab[0] = 1'b1;
    run_frame(0);
    check_frame("f01f");

    // Asynchronous reset in the middle of DATA
    load(2, 8'h00, 8'h00, 8'h00);
    Tx_Enable = 1'b1;
    for (int c = 0; c < 15; c++) tick(c);
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    chk("rst_async", 64'({Tx, Tx_ValidFrame, Tx_RdBuff, Tx_Done}), 64'b1000);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("rst_hold", 64'({Tx, Tx_ValidFrame, Tx_AbortedTrans}), 64'b100);
    Rst = 1'b0;
    load(2, 8'h00, 8'h00, 8'h00);
    exp_zero_frame();
    run_frame(-1);
    check_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
